// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer.
//   - default geometry (index / tag widths)
//   - entry type {valid, tag, target}
//   - index / tag extraction from a 32-bit PC
package btb_pkg;

  localparam int BTB_INDEX_W = 6;
  localparam int BTB_TAG_W   = 10;

  // Tag is held zero-extended to 32 bits so the type does not depend on the
  // per-instance TAG_W; unused upper bits are constant and trim away.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // Word-aligned index: pc[iw+1:2], returned right-justified.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned iw);
    return (pc >> 2) & ((32'd1 << iw) - 32'd1);
  endfunction

  // Tag: pc[iw+tw+1:iw+2], returned right-justified.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned iw,
                                         input int unsigned tw);
    return (pc >> (iw + 2)) & ((32'd1 << tw) - 32'd1);
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage.
//   clk, rst      : clock, async active-high reset (clears valid bits only)
//   i_inv_all     : clear every valid bit at the edge; also kills a same-cycle write
//   i_we          : write request (idx/tag/target) at the edge
//   i_ridx/i_rtag : combinational lookup; o_hit/o_target include write bypass
module btb_array
  import btb_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W,
  parameter int TAG_W   = BTB_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_inv_all,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_widx,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic [31:0]        i_wtarget,
  input  logic [INDEX_W-1:0] i_ridx,
  input  logic [TAG_W-1:0]   i_rtag,
  output logic               o_hit,
  output logic [31:0]        o_target
);
  localparam int N = 1 << INDEX_W;

  logic [N-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [N];
  logic [31:0]      r_target [N];

  logic       w_we;
  logic       w_byp;
  btb_entry_t w_rd;

  // inv_all has priority: the write is dropped entirely.
  assign w_we = i_we & ~i_inv_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_valid <= '0;
    else if (i_inv_all) r_valid <= '0;
    else if (w_we)      r_valid[i_widx] <= 1'b1;
  end

  // Tags/targets are only meaningful under a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_tag[i_widx]    <= i_wtag;
      r_target[i_widx] <= i_wtarget;
    end
  end

  // Read port: the in-flight write stands in for the stored entry.
  assign w_byp = w_we & (i_widx == i_ridx);

  always_comb begin
    w_rd.valid  = r_valid[i_ridx];
    w_rd.tag    = 32'(r_tag[i_ridx]);
    w_rd.target = r_target[i_ridx];
    if (w_byp) begin
      w_rd.valid  = 1'b1;
      w_rd.tag    = 32'(i_wtag);
      w_rd.target = i_wtarget;
    end
  end

  assign o_hit    = w_rd.valid & (w_rd.tag == 32'(i_rtag));
  assign o_target = o_hit ? w_rd.target : 32'd0;

endmodule

// File: rtl/branch_target_buffer.sv
// Branch target buffer: F-stage lookup, F->D pipeline register, M-stage training.
//   clk, rst              : clock, async active-high reset
//   stallD / flushD       : hold / clear the F->D register (flush wins)
//   pcF                   : fetch PC looked up every cycle
//   inv_all               : invalidate all entries (beats a same-cycle update)
//   updateM, pcM, targetM : install resolved taken target
//   btb_hitF/btb_targetF  : combinational lookup result
//   btb_hitD/btb_targetD  : registered lookup result
//   lookup_cnt/hit_cnt    : capture statistics, built only with BTB_STATS_EN
//                           defined, otherwise tied to 0
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W,
  parameter int TAG_W   = BTB_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic        inv_all,
  input  logic        updateM,
  input  logic [31:0] pcM,
  input  logic [31:0] targetM,
  output logic        btb_hitF,
  output logic [31:0] btb_targetF,
  output logic        btb_hitD,
  output logic [31:0] btb_targetD,
  output logic [31:0] lookup_cnt,
  output logic [31:0] hit_cnt
);
  logic [INDEX_W-1:0] w_idxF, w_idxM;
  logic [TAG_W-1:0]   w_tagF, w_tagM;
  logic               w_cap;

  assign w_idxF = INDEX_W'(pc_index(pcF, INDEX_W));
  assign w_idxM = INDEX_W'(pc_index(pcM, INDEX_W));
  assign w_tagF = TAG_W'(pc_tag(pcF, INDEX_W, TAG_W));
  assign w_tagM = TAG_W'(pc_tag(pcM, INDEX_W, TAG_W));

  btb_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_inv_all (inv_all),
    .i_we      (updateM),
    .i_widx    (w_idxM),
    .i_wtag    (w_tagM),
    .i_wtarget (targetM),
    .i_ridx    (w_idxF),
    .i_rtag    (w_tagF),
    .o_hit     (btb_hitF),
    .o_target  (btb_targetF)
  );

  assign w_cap = ~stallD & ~flushD;

  logic        r_hitD;
  logic [31:0] r_targetD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hitD    <= 1'b0;
      r_targetD <= 32'd0;
    end else if (flushD) begin
      r_hitD    <= 1'b0;
      r_targetD <= 32'd0;
    end else if (!stallD) begin
      r_hitD    <= btb_hitF;
      r_targetD <= btb_targetF;
    end
  end

  assign btb_hitD    = r_hitD;
  assign btb_targetD = r_targetD;

`ifdef BTB_STATS_EN
  logic [31:0] r_lookup_cnt, r_hit_cnt;

  // Saturating counters; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lookup_cnt <= 32'd0;
      r_hit_cnt    <= 32'd0;
    end else if (w_cap) begin
      if (r_lookup_cnt != 32'hFFFF_FFFF)            r_lookup_cnt <= r_lookup_cnt + 32'd1;
      if (btb_hitF && r_hit_cnt != 32'hFFFF_FFFF)   r_hit_cnt    <= r_hit_cnt + 32'd1;
    end
  end

  assign lookup_cnt = r_lookup_cnt;
  assign hit_cnt    = r_hit_cnt;
`else
  logic w_unused;
  assign w_unused   = w_cap;
  assign lookup_cnt = 32'd0;
  assign hit_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst, stallD, flushD, inv_all, updateM;
  logic [31:0] pcF, pcM, targetM;
  logic        btb_hitF, btb_hitD;
  logic [31:0] btb_targetF, btb_targetD, lookup_cnt, hit_cnt;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF),
    .inv_all(inv_all), .updateM(updateM), .pcM(pcM), .targetM(targetM),
    .btb_hitF(btb_hitF), .btb_targetF(btb_targetF),
    .btb_hitD(btb_hitD), .btb_targetD(btb_targetD),
    .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic hit; logic [31:0] tgt; } exp_t;
  exp_t q[$];
  exp_t dlast;
  int n_chk = 0, n_fail = 0;
  int unsigned m_lk = 0, m_ht = 0;

  function automatic logic [31:0] exp_lk();
`ifdef BTB_STATS_EN
    return m_lk;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_ht();
`ifdef BTB_STATS_EN
    return m_ht;
`else
    return 32'd0;
`endif
  endfunction

  // One cycle: drive F/M inputs, check F outputs mid-cycle, queue the D
  // expectation, then check D and counters just after the edge.
  task automatic cyc(input string nm, input logic [31:0] pc,
                     input logic upd, input logic [31:0] pm, input logic [31:0] tm,
                     input logic inv, input logic stall, input logic flush,
                     input logic eh, input logic [31:0] et);
    exp_t e, g;
    pcF = pc; updateM = upd; pcM = pm; targetM = tm;
    inv_all = inv; stallD = stall; flushD = flush;
    #2;
    n_chk++;
    if (btb_hitF !== eh || btb_targetF !== et) begin
      n_fail++;
      $display("FAIL %s F: got hit=%b tgt=%h, want hit=%b tgt=%h", nm, btb_hitF, btb_targetF, eh, et);
    end
    if (flush) begin
      e.hit = 1'b0; e.tgt = 32'd0;
    end else if (!stall) begin
      e.hit = eh; e.tgt = et;
      m_lk++;
      if (eh) m_ht++;
    end else begin
      e = dlast;
    end
    q.push_back(e);
    dlast = e;
    @(posedge clk); #1;
    updateM = 1'b0; inv_all = 1'b0; stallD = 1'b0; flushD = 1'b0;
    g = q.pop_front();
    n_chk++;
    if (btb_hitD !== g.hit || btb_targetD !== g.tgt) begin
      n_fail++;
      $display("FAIL %s D: got hit=%b tgt=%h, want hit=%b tgt=%h", nm, btb_hitD, btb_targetD, g.hit, g.tgt);
    end
    n_chk++;
    if (lookup_cnt !== exp_lk() || hit_cnt !== exp_ht()) begin
      n_fail++;
      $display("FAIL %s cnt: got lk=%0d ht=%0d, want lk=%0d ht=%0d", nm, lookup_cnt, hit_cnt, exp_lk(), exp_ht());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_lk = 0; m_ht = 0;
    dlast.hit = 1'b0; dlast.tgt = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallD = 0; flushD = 0; inv_all = 0; updateM = 0;
    pcF = 32'h40; pcM = 0; targetM = 0;
    @(posedge clk); #1;
    n_chk++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'd0 || lookup_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got hitD=%b tgtD=%h lk=%0d ht=%0d, want all 0", btb_hitD, btb_targetD, lookup_cnt, hit_cnt);
    end
    rst = 1'b0;
    dlast.hit = 1'b0; dlast.tgt = 32'd0;
    cyc("reset_lookup", 32'h40, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_update();
    cyc("upd_write", 32'h0, 1, 32'h40, 32'h1000, 0, 0, 0, 1'b0, 32'h0);
    cyc("upd_hit",   32'h40, 0, 0, 0, 0, 0, 0, 1'b1, 32'h1000);
  endtask

  task automatic test_alias();
    cyc("alias_miss",   32'h1040, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
    cyc("alias_write",  32'h0, 1, 32'h1040, 32'h2000, 0, 0, 0, 1'b0, 32'h0);
    cyc("alias_new",    32'h1040, 0, 0, 0, 0, 0, 0, 1'b1, 32'h2000);
    cyc("alias_old",    32'h40, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_bypass();
    cyc("byp_hit",      32'h80, 1, 32'h80, 32'h300, 0, 0, 0, 1'b1, 32'h300);
    cyc("byp_stored",   32'h80, 0, 0, 0, 0, 0, 0, 1'b1, 32'h300);
    cyc("inv_clear",    32'h0, 0, 0, 0, 1, 0, 0, 1'b0, 32'h0);
    cyc("inv_after",    32'h1040, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
    cyc("byp_inv",      32'h80, 1, 32'h80, 32'h300, 1, 0, 0, 1'b0, 32'h0);
    cyc("byp_inv_post", 32'h80, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_pipeline();
    cyc("pipe_write", 32'h0, 1, 32'h40, 32'h1000, 0, 0, 0, 1'b0, 32'h0);
    cyc("pipe_hit",   32'h40, 0, 0, 0, 0, 0, 0, 1'b1, 32'h1000);
    cyc("stall1", 32'h80,   0, 0, 0, 0, 1, 0, 1'b0, 32'h0);
    cyc("stall2", 32'h1040, 0, 0, 0, 0, 1, 0, 1'b0, 32'h0);
    cyc("stall3", 32'h0,    0, 0, 0, 0, 1, 0, 1'b0, 32'h0);
    cyc("stall_flush", 32'h40, 0, 0, 0, 0, 1, 1, 1'b1, 32'h1000);
    cyc("pre_rst", 32'h40, 0, 0, 0, 0, 0, 0, 1'b1, 32'h1000);
    // Async reset between edges.
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'd0 || btb_hitF !== 1'b0 || lookup_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst: got hitD=%b tgtD=%h hitF=%b lk=%0d ht=%0d, want all 0", btb_hitD, btb_targetD, btb_hitF, lookup_cnt, hit_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_lk = 0; m_ht = 0;
    dlast.hit = 1'b0; dlast.tgt = 32'd0;
  endtask

  task automatic test_stats();
    do_reset();
    cyc("st1", 32'h0,   1, 32'h40, 32'h1000, 0, 0, 0, 1'b0, 32'h0);
    cyc("st2", 32'h40,  0, 0, 0, 0, 0, 0, 1'b1, 32'h1000);
    cyc("st_stall", 32'h80, 0, 0, 0, 0, 1, 0, 1'b0, 32'h0);
    cyc("st3", 32'h40,  0, 0, 0, 0, 0, 0, 1'b1, 32'h1000);
    cyc("st4", 32'h100, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
    cyc("st5", 32'h200, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
    n_chk++;
`ifdef BTB_STATS_EN
    if (lookup_cnt !== 32'd5 || hit_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_total: got lk=%0d ht=%0d, want lk=5 ht=2", lookup_cnt, hit_cnt);
    end
`else
    if (lookup_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_total: got lk=%0d ht=%0d, want lk=0 ht=0", lookup_cnt, hit_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_update();
    test_alias();
    test_bypass();
    test_pipeline();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
